// File: rtl/stat_pkg.sv
// Shared constants for the pet stat register file: opcodes, stat indices
// and the default geometry of the stat file.
package stat_pkg;

  localparam int STAT_VW    = 3;
  localparam int STAT_NSTAT = 5;

  localparam logic [1:0] OP_DEC      = 2'b00;
  localparam logic [1:0] OP_INC      = 2'b01;
  localparam logic [1:0] OP_CLEAR    = 2'b10;
  localparam logic [1:0] OP_LOAD_MAX = 2'b11;

  localparam logic [2:0] STAT_FOOD   = 3'd0;
  localparam logic [2:0] STAT_SLEEP  = 3'd1;
  localparam logic [2:0] STAT_FUN    = 3'd2;
  localparam logic [2:0] STAT_HAPPY  = 3'd3;
  localparam logic [2:0] STAT_HEALTH = 3'd4;

endpackage

// File: rtl/stat_update_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
// The pointer moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_gntIdx,
  output logic            o_found
);

  logic [PW-1:0] r_ptr;

  // Pick the first asserted request at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    o_gnt    = '0;
    o_gntIdx = '0;
    o_found  = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!o_found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        o_gntIdx   = PW'(idx);
        o_found    = 1'b1;
      end
    end
  end

  // Advance the pointer to one past the winner after each accepted grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      if (int'(o_gntIdx) == NREQ - 1) r_ptr <= '0;
      else                            r_ptr <= o_gntIdx + PW'(1);
    end
  end

endmodule

// File: rtl/stat_update_arbiter.sv
// Central owner of the pet stats: serializes update requests from several
// requesters onto one stat file with saturating arithmetic.
module stat_update_arbiter
  import stat_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int NSTAT      = STAT_NSTAT,
  parameter int VW         = STAT_VW,
  parameter int INIT_VALUE = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [3*NREQ-1:0]   req_stat,
  input  logic [2*NREQ-1:0]   req_op,
  output logic [NREQ-1:0]     req_ready,
  output logic [VW*NSTAT-1:0] stat_values,
  output logic                upd_valid,
  output logic [2:0]          upd_stat,
  output logic [2:0]          upd_src,
  output logic                err_pulse
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [VW-1:0] MAXV  = {VW{1'b1}};
  localparam logic [VW-1:0] INITV = VW'(INIT_VALUE);

  logic [VW-1:0]   r_stats [NSTAT];
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gntIdx;
  logic            w_found;
  logic            w_xfer;
  logic [2:0]      w_selStat;
  logic [1:0]      w_selOp;
  logic            w_badIdx;
  logic [VW-1:0]   w_old;
  logic [VW-1:0]   w_new;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_gntIdx  (w_gntIdx),
    .o_found   (w_found)
  );

  assign req_ready = rst ? w_gnt : '0;
  assign w_xfer    = rst & w_found;
  assign w_selStat = req_stat[3*int'(w_gntIdx) +: 3];
  assign w_selOp   = req_op[2*int'(w_gntIdx) +: 2];
  assign w_badIdx  = (int'(w_selStat) >= NSTAT);

  // Read the current value of the granted stat and compute its saturated successor.
  always_comb begin
    w_old = '0;
    for (int k = 0; k < NSTAT; k++) begin
      if (int'(w_selStat) == k) w_old = r_stats[k];
    end
    unique case (w_selOp)
      OP_DEC:   w_new = (w_old == '0)   ? w_old : w_old - VW'(1);
      OP_INC:   w_new = (w_old == MAXV) ? w_old : w_old + VW'(1);
      OP_CLEAR: w_new = '0;
      default:  w_new = MAXV;
    endcase
  end

  // Commit the accepted request and raise the one-cycle change/error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NSTAT; k++) r_stats[k] <= INITV;
      upd_valid <= 1'b0;
      upd_stat  <= '0;
      upd_src   <= '0;
      err_pulse <= 1'b0;
    end else begin
      upd_valid <= 1'b0;
      err_pulse <= 1'b0;
      if (w_xfer) begin
        if (w_badIdx) begin
          err_pulse <= 1'b1;
        end else if (w_new != w_old) begin
          for (int k = 0; k < NSTAT; k++) begin
            if (int'(w_selStat) == k) r_stats[k] <= w_new;
          end
          upd_valid <= 1'b1;
          upd_stat  <= w_selStat;
          upd_src   <= 3'(w_gntIdx);
        end
      end
    end
  end

  // Flatten the stat file onto the output bus.
  always_comb begin
    stat_values = '0;
    for (int k = 0; k < NSTAT; k++) stat_values[VW*k +: VW] = r_stats[k];
  end

endmodule

// File: doc/stat_update_arbiter.md
# stat_update_arbiter

Central owner of the five pet stat values (food, sleep, fun, happy, health). It serializes increment/decrement/clear/load requests from several independent requesters (decay FSMs, button-action logic, health-penalty logic, debug) onto a single stat register file, with round-robin fairness and saturating 3-bit arithmetic. It sits between the per-need state machines and the display/LED drivers, replacing ad-hoc per-stat up/down pulse wiring.

## Interface
- NREQ, 4, number of requester ports (2..8)
- NSTAT, 5, number of stats held
- VW, 3, stat value width
- INIT_VALUE, 7, stat value after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  request pending, per requester
- req_stat  in  3*NREQ  stat index per requester (slice i = bits 3i+2:3i)
- req_op  in  2*NREQ  opcode per requester: 00 DEC, 01 INC, 10 CLEAR (to 0), 11 LOAD_MAX (to 2^VW-1)
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- stat_values  out  VW*NSTAT  stat k at bits VW*k+VW-1:VW*k
- upd_valid  out  1  one-cycle pulse: a stat changed value last edge
- upd_stat  out  3  index of stat changed
- upd_src  out  3  requester index that caused the change
- err_pulse  out  1  one-cycle pulse: accepted request had index >= NSTAT

## Operation
- Reset (rst=0 at posedge): all stats = INIT_VALUE; rr pointer = 0; upd_valid, upd_stat, upd_src, err_pulse = 0. req_ready forced to 0 while rst=0.
- Arbitration: round-robin among asserted req_valid; search starts at pointer. At most one grant per cycle. After a transfer from requester g, pointer = (g+1) mod NREQ; pointer unchanged when no transfer.
- req_ready is combinational from req_valid and pointer; requester holds valid, stat, op stable until transfer. req_valid may drop without transfer (no penalty).
- Apply at the transfer edge, for stat s = req_stat[g]:
  - DEC: s = max(s-1, 0); INC: s = min(s+1, 2^VW-1); CLEAR: 0; LOAD_MAX: 2^VW-1.
  - Saturation: DEC at 0 / INC at max is accepted (ready asserted) but value unchanged; upd_valid stays 0.
  - upd_valid=1 only if new value differs from old; upd_stat=s, upd_src=g registered same edge.
  - s >= NSTAT: accepted, no stat modified, err_pulse=1 for one cycle, upd_valid=0.
- Same-stat requests from different requesters in one cycle: serialized by arbitration; each applied to the value left by the previous one.
- Bounded wait: a continuously asserted requester is granted within NREQ cycles.

## Timing
- Grant: same cycle as req_valid (zero-latency combinational ready).
- stat_values reflects a transfer one cycle after the transfer edge (registered outputs, no combinational path from req to stat_values).
- upd_valid/err_pulse: high exactly the cycle after the transfer edge, low otherwise.
- Throughput: one update per cycle sustained.
- Reset mid-operation: pending request dropped, no partial update; requester must re-present after rst=1.

## Structure
- Shared package stat_pkg: opcodes OP_DEC/OP_INC/OP_CLEAR/OP_LOAD_MAX; stat indices STAT_FOOD=0, STAT_SLEEP=1, STAT_FUN=2, STAT_HAPPY=3, STAT_HEALTH=4; VW, NSTAT defaults.
- Sub-module rr_arbiter (NREQ-wide req in, one-hot gnt out, pointer register and advance-on-accept input) instantiated once; the stat file and saturating ALU live in stat_update_arbiter.

## Test plan
- Reset: rst=0 two cycles -> all stats 7, req_ready=0, upd_valid=0; after rst=1 idle stats stay 7.
- Single DEC: req 0 DEC food x3 -> food 7->6->5->4, one upd_valid each with upd_stat=0, upd_src=0; ready high each cycle.
- Round-robin: req 0,1,2,3 all valid, DEC health continuously -> grants 0,1,2,3,0,...; health 7->3 after 4 cycles, each upd_src matching.
- Saturation: CLEAR fun then DEC fun twice -> fun 0, DECs accepted, upd_valid 0; LOAD_MAX then INC -> 7, INC gives no upd_valid.
- Bad index: req 2 INC with stat=6 -> ready high, err_pulse one cycle, all stats unchanged, pointer advances to 3.
- Reset mid-stream: req 1 holding DEC sleep, assert rst=0 in cycle of grant -> no transfer, sleep=7, pointer=0 after reset.
